mult_seq_nxm: RTL

- Parametrised sequential multiplier: an A_WIDTH x B_WIDTH product built from CHUNK x CHUNK partial products, one per clock.
- Contains both the control FSM and the datapath: operand capture, chunk select, shift, accumulate, sign fix-up.
- Next generation of the team's fixed 32x32 four-cycle multiplier. Adds generic widths, a signed mode, a done pulse and a guaranteed fixed latency.
- Sits between an operand-issuing controller and a result consumer. The handshake is start/busy/done.

---
 rtl/mult_seq_pkg.sv | 16 +
 rtl/mult_seq_ctrl.sv | 82 ++++++++
 rtl/mult_seq_nxm.sv | 84 ++++++++
 3 files changed

// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the sequential chunked multiplier.
package mult_seq_pkg;

  typedef enum logic [1:0] {IDLE, MAC, FIX} mult_state_t;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int k = 1; k < 31; k++) begin
      if ((1 << k) < n) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_seq_ctrl.sv
// Control FSM for the sequential multiplier: phase strobes, chunk indices,
// busy and the one-cycle done pulse.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int NA = 2,
  parameter int NB = 2,
  parameter int IW = 1,
  parameter int JW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          capture,
  output logic          accumulate,
  output logic          fix,
  output logic [IW-1:0] i,
  output logic [JW-1:0] j
);

  mult_state_t state, state_nxt;
  logic        i_last;
  logic        last_pp;

  assign i_last  = (i == IW'(NA - 1));
  assign last_pp = i_last && (j == JW'(NB - 1));
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    accumulate = 1'b0;
    fix        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC: begin
        accumulate = 1'b1;
        if (last_pp) state_nxt = FIX;
      end
      FIX: begin
        fix       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // i walks the A chunks fastest; j advances once per full sweep of A.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i    <= '0;
      j    <= '0;
      done <= 1'b0;
    end else begin
      done <= fix;
      if (capture) begin
        i <= '0;
        j <= '0;
      end else if (accumulate) begin
        if (i_last) begin
          i <= '0;
          j <= j + JW'(1);
        end else begin
          i <= i + IW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mult_seq_nxm.sv
// A_WIDTH x B_WIDTH multiplier built from one CHUNK x CHUNK partial product
// per clock, with signed mode via magnitude capture and a final negation.
module mult_seq_nxm
  import mult_seq_pkg::*;
#(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32,
  parameter int CHUNK   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       is_signed,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  output logic                       busy,
  output logic                       done,
  output logic [A_WIDTH+B_WIDTH-1:0] product
);

  localparam int NA      = A_WIDTH / CHUNK;
  localparam int NB      = B_WIDTH / CHUNK;
  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int IW      = clog2_min1(NA);
  localparam int JW      = clog2_min1(NB);

  function automatic logic [P_WIDTH-1:0] sign_fix(input logic [P_WIDTH-1:0] v,
                                                  input logic n);
    return n ? (~v + P_WIDTH'(1)) : v;
  endfunction

  logic                 capture, accumulate, fix;
  logic [IW-1:0]        i;
  logic [JW-1:0]        j;
  logic [A_WIDTH-1:0]   a_mag;
  logic [B_WIDTH-1:0]   b_mag;
  logic                 neg;
  logic [CHUNK-1:0]     a_chunk, b_chunk;
  logic [2*CHUNK-1:0]   pp;
  logic [P_WIDTH-1:0]   pp_shifted;

  mult_seq_ctrl #(
    .NA(NA),
    .NB(NB),
    .IW(IW),
    .JW(JW)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .capture    (capture),
    .accumulate (accumulate),
    .fix        (fix),
    .i          (i),
    .j          (j)
  );

  assign a_chunk    = a_mag[i*CHUNK +: CHUNK];
  assign b_chunk    = b_mag[j*CHUNK +: CHUNK];
  assign pp         = {{CHUNK{1'b0}}, a_chunk} * {{CHUNK{1'b0}}, b_chunk};
  assign pp_shifted = P_WIDTH'(pp) << (CHUNK * (int'(i) + int'(j)));

  // Magnitudes of the most-negative operand still fit in the unsigned width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_mag   <= '0;
      b_mag   <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (capture) begin
      a_mag   <= (is_signed && a[A_WIDTH-1]) ? -a : a;
      b_mag   <= (is_signed && b[B_WIDTH-1]) ? -b : b;
      neg     <= is_signed & (a[A_WIDTH-1] ^ b[B_WIDTH-1]);
      product <= '0;
    end else if (accumulate) begin
      product <= product + pp_shifted;
    end else if (fix) begin
      product <= sign_fix(product, neg);
    end
  end

endmodule
